// File: rtl/mod_mapper.sv
// Runtime-selectable BPSK / QPSK / 16-QAM symbol mapper.
// Each accepted byte is unpacked MSB-first into 8/4/2 symbols. The symbols leave
// through a registered I/Q output stage, and the byte sideband travels with them.
module mod_mapper #(
    parameter int DATA_W   = 16,
    parameter int AMP_BPSK = 32767,
    parameter int AMP_QPSK = 23170,
    parameter int QAM_D    = 10362
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [7:0]        s_axis_data,
    input  logic              s_axis_last,
    input  logic              s_axis_sop,
    input  logic              s_axis_is_parity,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic [DATA_W-1:0] m_axis_i,
    output logic [DATA_W-1:0] m_axis_q,
    output logic              m_axis_last,
    output logic              m_axis_sop,
    output logic              m_axis_is_parity
);

    // Every amplitude, including 3d, has to leave the sign bit free.
    if (AMP_BPSK >= (1 << (DATA_W - 1)) || AMP_QPSK >= (1 << (DATA_W - 1)) ||
        3 * QAM_D >= (1 << (DATA_W - 1))) begin : g_amp_check
        $error("mod_mapper: amplitude does not fit in DATA_W-1 bits");
    end

    localparam logic signed [DATA_W-1:0] B_POS  = DATA_W'(AMP_BPSK);
    localparam logic signed [DATA_W-1:0] B_NEG  = -B_POS;
    localparam logic signed [DATA_W-1:0] Q_POS  = DATA_W'(AMP_QPSK);
    localparam logic signed [DATA_W-1:0] Q_NEG  = -Q_POS;
    localparam logic signed [DATA_W-1:0] D1_POS = DATA_W'(QAM_D);
    localparam logic signed [DATA_W-1:0] D1_NEG = -D1_POS;
    localparam logic signed [DATA_W-1:0] D3_POS = DATA_W'(3 * QAM_D);
    localparam logic signed [DATA_W-1:0] D3_NEG = -D3_POS;

    // Index of the final symbol of a byte: 7 for BPSK, 1 for 16QAM, otherwise 3
    // (QPSK, and the reserved code, which is treated as QPSK).
    function automatic logic [2:0] last_idx(input logic [1:0] mode);
        logic [2:0] idx;
        case (mode)
            2'd0:    idx = 3'd7;
            2'd2:    idx = 3'd1;
            default: idx = 3'd3;
        endcase
        return idx;
    endfunction

    // Gray-coded 16QAM level for one axis: 00 +3d, 01 +d, 11 -d, 10 -3d.
    function automatic logic [DATA_W-1:0] qam_level(input logic [1:0] b);
        return b[1] ? (b[0] ? D1_NEG : D3_NEG) : (b[0] ? D1_POS : D3_POS);
    endfunction

    // Symbol k of a byte as {I, Q}; the byte is shifted so that the symbol bits sit at the MSB.
    function automatic logic [2*DATA_W-1:0] map_sym(input logic [1:0] mode,
                                                   input logic [7:0] data,
                                                   input logic [2:0] k);
        logic [7:0]        sh;
        logic [DATA_W-1:0] i_v;
        logic [DATA_W-1:0] q_v;
        sh  = data;
        i_v = '0;
        q_v = '0;
        case (mode)
            2'd0: begin
                sh  = data << k;
                i_v = sh[7] ? B_NEG : B_POS;
            end
            2'd2: begin
                sh  = data << {k[0], 2'b00};
                i_v = qam_level(sh[7:6]);
                q_v = qam_level(sh[5:4]);
            end
            default: begin
                sh  = data << {k[1:0], 1'b0};
                i_v = sh[7] ? Q_NEG : Q_POS;
                q_v = sh[6] ? Q_NEG : Q_POS;
            end
        endcase
        return {i_v, q_v};
    endfunction

    logic [7:0]        byte_q, byte_d;
    logic              byte_last_q, byte_last_d;
    logic              byte_par_q, byte_par_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              mode_ok_q, mode_ok_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_i_q, out_i_d;
    logic [DATA_W-1:0] out_q_q, out_q_d;
    logic              out_sop_q, out_sop_d;
    logic              out_last_q, out_last_d;
    logic              out_par_q, out_par_d;

    logic              final_sym;
    logic              accept;
    logic [1:0]        mode_new;
    logic [2*DATA_W-1:0] sym;

    // A new byte may enter when the output stage is empty or its last symbol is leaving.
    assign final_sym    = (cnt_q == last_idx(mode_q));
    assign s_axis_ready = rst_n & (~out_valid_q | (m_axis_ready & final_sym));
    assign accept       = s_axis_valid & s_axis_ready;
    // Mode follows cfg_mode only at a block start, or for the first byte after reset.
    assign mode_new     = (s_axis_sop || !mode_ok_q) ? cfg_mode : mode_q;

    // Next-state: load a new byte, step to the next symbol, or drain the output stage.
    always_comb begin
        byte_d      = byte_q;
        byte_last_d = byte_last_q;
        byte_par_d  = byte_par_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        mode_ok_d   = mode_ok_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_sop_d   = out_sop_q;
        out_last_d  = out_last_q;
        out_par_d   = out_par_q;
        sym         = '0;
        if (accept) begin
            byte_d      = s_axis_data;
            byte_last_d = s_axis_last;
            byte_par_d  = s_axis_is_parity;
            mode_d      = mode_new;
            mode_ok_d   = 1'b1;
            cnt_d       = 3'd0;
            sym         = map_sym(mode_new, s_axis_data, 3'd0);
            out_valid_d = 1'b1;
            out_i_d     = sym[2*DATA_W-1:DATA_W];
            out_q_d     = sym[DATA_W-1:0];
            out_sop_d   = s_axis_sop;
            out_last_d  = s_axis_last && (last_idx(mode_new) == 3'd0);
            out_par_d   = s_axis_is_parity;
        end else if (out_valid_q && m_axis_ready && !final_sym) begin
            cnt_d       = cnt_q + 3'd1;
            sym         = map_sym(mode_q, byte_q, cnt_d);
            out_i_d     = sym[2*DATA_W-1:DATA_W];
            out_q_d     = sym[DATA_W-1:0];
            out_sop_d   = 1'b0;
            out_last_d  = byte_last_q && (cnt_d == last_idx(mode_q));
            out_par_d   = byte_par_q;
        end else if (m_axis_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards the pending byte and the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q      <= '0;
            byte_last_q <= 1'b0;
            byte_par_q  <= 1'b0;
            cnt_q       <= '0;
            mode_q      <= '0;
            mode_ok_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_sop_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_par_q   <= 1'b0;
        end else begin
            byte_q      <= byte_d;
            byte_last_q <= byte_last_d;
            byte_par_q  <= byte_par_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mode_ok_q   <= mode_ok_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_sop_q   <= out_sop_d;
            out_last_q  <= out_last_d;
            out_par_q   <= out_par_d;
        end
    end

    assign m_axis_valid     = out_valid_q;
    assign m_axis_i         = out_i_q;
    assign m_axis_q         = out_q_q;
    assign m_axis_sop       = out_sop_q;
    assign m_axis_last      = out_last_q;
    assign m_axis_is_parity = out_par_q;

endmodule

// File: tb/tb_mod_mapper.sv
// Bench for mod_mapper: a symbol-list model checked every output cycle, plus
// hand-computed literal vectors for the directed cases.
module tb_mod_mapper;

    localparam int AB = 32767;
    localparam int AQ = 23170;
    localparam int D  = 10362;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [7:0]  s_axis_data;
    logic        s_axis_last;
    logic        s_axis_sop;
    logic        s_axis_is_parity;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [15:0] m_axis_i;
    logic [15:0] m_axis_q;
    logic        m_axis_last;
    logic        m_axis_sop;
    logic        m_axis_is_parity;

    mod_mapper dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_mode         (cfg_mode),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .s_axis_last      (s_axis_last),
        .s_axis_sop       (s_axis_sop),
        .s_axis_is_parity (s_axis_is_parity),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_i         (m_axis_i),
        .m_axis_q         (m_axis_q),
        .m_axis_last      (m_axis_last),
        .m_axis_sop       (m_axis_sop),
        .m_axis_is_parity (m_axis_is_parity)
    );

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        sop;
        logic        last;
        logic        par;
    } sym_t;

    sym_t exp_q[$];
    sym_t got[$];
    int   got_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_sop = 0;
    int   n_last = 0;
    int   m_mode = 0;
    bit   m_have = 0;
    bit   rnd_rdy = 0;
    bit   rdy_val = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Model: expand an accepted byte into its list of symbols.
    task automatic model_accept(input logic [7:0] d, input logic sop, input logic last,
                                input logic par, input logic [1:0] cfg);
        int   eff, bps, nsym, bits, iv, qv;
        int   lv[4];
        sym_t s;
        lv[0] = 3 * D; lv[1] = D; lv[2] = -3 * D; lv[3] = -D;
        if (sop || !m_have) begin
            m_mode = int'(cfg);
            m_have = 1;
        end
        eff  = (m_mode == 3) ? 1 : m_mode;
        bps  = (eff == 0) ? 1 : (eff == 1) ? 2 : 4;
        nsym = 8 / bps;
        for (int k = 0; k < nsym; k++) begin
            bits = (int'(d) >> (8 - (k + 1) * bps)) & ((1 << bps) - 1);
            if (eff == 0) begin
                iv = (bits != 0) ? -AB : AB;
                qv = 0;
            end else if (eff == 1) begin
                iv = ((bits & 2) != 0) ? -AQ : AQ;
                qv = ((bits & 1) != 0) ? -AQ : AQ;
            end else begin
                iv = lv[bits >> 2];
                qv = lv[bits & 3];
            end
            s.i    = 16'(iv);
            s.q    = 16'(qv);
            s.sop  = sop && (k == 0);
            s.last = last && (k == nsym - 1);
            s.par  = par;
            exp_q.push_back(s);
        end
    endtask

    // Compare process: checks outputs every cycle they are meaningful.
    task automatic monitor_loop();
        sym_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                m_have = 0;
                m_mode = 0;
                checks++;
                if (m_axis_valid !== 1'b0 || m_axis_i !== 16'h0 || m_axis_q !== 16'h0 ||
                    m_axis_sop !== 1'b0 || m_axis_last !== 1'b0 ||
                    m_axis_is_parity !== 1'b0 || s_axis_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state: valid=%b i=%h q=%h sop=%b last=%b par=%b ready=%b, required all 0",
                             m_axis_valid, m_axis_i, m_axis_q, m_axis_sop, m_axis_last,
                             m_axis_is_parity, s_axis_ready);
                end
            end else begin
                if (m_axis_valid) begin
                    a.i = m_axis_i; a.q = m_axis_q; a.sop = m_axis_sop;
                    a.last = m_axis_last; a.par = m_axis_is_parity;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL stray_symbol: got i=%h q=%h, required no symbol", a.i, a.q);
                    end else if (a !== exp_q[0]) begin
                        failures++;
                        $display("FAIL symbol: got i=%h q=%h sop=%b last=%b par=%b, required i=%h q=%h sop=%b last=%b par=%b",
                                 a.i, a.q, a.sop, a.last, a.par, exp_q[0].i, exp_q[0].q,
                                 exp_q[0].sop, exp_q[0].last, exp_q[0].par);
                    end
                    if (m_axis_ready) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got.push_back(a);
                        got_cyc.push_back(cyc);
                        if (a.sop) n_sop++;
                        if (a.last) n_last++;
                    end
                end
                if (s_axis_valid && s_axis_ready)
                    model_accept(s_axis_data, s_axis_sop, s_axis_last, s_axis_is_parity, cfg_mode);
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            m_axis_ready = rnd_rdy ? ($urandom_range(0, 7) != 0) : rdy_val;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sop, input logic last,
                        input logic par, input logic [1:0] mode);
        int n = 0;
        bit took = 0;
        s_axis_data = d; s_axis_sop = sop; s_axis_last = last;
        s_axis_is_parity = par; cfg_mode = mode; s_axis_valid = 1'b1;
        while (!took && n < 1000) begin
            @(negedge clk);
            took = s_axis_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_axis_valid = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h not accepted within 1000 cycles", d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL drain_timeout: %0d symbols outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [15:0] t1_i[4];
        logic [15:0] t1_q[4];
        logic [15:0] t2_i[8];
        int sop_base, last_base;
        t1_i = '{16'h5A82, 16'h5A82, 16'hA57E, 16'hA57E};
        t1_q = '{16'h5A82, 16'hA57E, 16'h5A82, 16'hA57E};
        t2_i = '{16'h8001, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001};

        rst_n = 0; cfg_mode = 2'd1; s_axis_valid = 0; s_axis_data = 0;
        s_axis_last = 0; s_axis_sop = 0; s_axis_is_parity = 0; m_axis_ready = 1;
        fork
            monitor_loop();
            ready_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", m_axis_valid, 0);

        // T1: QPSK 0x1B as a one-byte block
        clear_got();
        send(8'h1B, 1, 1, 0, 2'd1);
        drain();
        chk("t1_count", got.size(), 4);
        if (got.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t1_i%0d", k), got[k].i, t1_i[k]);
                chk($sformatf("t1_q%0d", k), got[k].q, t1_q[k]);
                chk($sformatf("t1_sop%0d", k), got[k].sop, k == 0);
                chk($sformatf("t1_last%0d", k), got[k].last, k == 3);
            end
        end

        // Back-to-back bytes must stream without a bubble
        clear_got();
        send(8'h36, 1, 0, 0, 2'd1);
        send(8'hC9, 0, 1, 1, 2'd1);
        drain();
        chk("b2b_count", got.size(), 8);
        if (got.size() == 8) chk("b2b_span", got_cyc[7] - got_cyc[0], 7);

        // T2: BPSK 0xA5
        clear_got();
        send(8'hA5, 1, 1, 0, 2'd0);
        drain();
        chk("t2_count", got.size(), 8);
        if (got.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("t2_i%0d", k), got[k].i, t2_i[k]);
                chk($sformatf("t2_q%0d", k), got[k].q, 16'h0000);
            end
        end

        // T3: 16QAM 0x8D -> (-3d,+3d), (-d,+d)
        clear_got();
        send(8'h8D, 1, 1, 1, 2'd2);
        drain();
        chk("t3_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_i0", got[0].i, 16'h8692);
            chk("t3_q0", got[0].q, 16'h796E);
            chk("t3_i1", got[1].i, 16'hD786);
            chk("t3_q1", got[1].q, 16'h287A);
            chk("t3_par", {got[0].par, got[1].par}, 2'b11);
        end

        // T4: mode change mid-block is ignored; next sop block uses it; code 3 acts as QPSK
        clear_got();
        send(8'h1B, 1, 0, 0, 2'd1);
        send(8'hE4, 0, 0, 0, 2'd2);
        send(8'h72, 0, 0, 0, 2'd2);
        send(8'h0F, 0, 1, 0, 2'd2);
        send(8'h8D, 1, 1, 0, 2'd2);
        send(8'h4E, 1, 1, 0, 2'd3);
        drain();
        chk("t4_count", got.size(), 22);
        if (got.size() == 22) begin
            chk("t4_midblock_i", got[4].i, 16'hA57E);
            chk("t4_midblock_q", got[4].q, 16'hA57E);
            chk("t4_next_block_i", got[16].i, 16'h8692);
            chk("t4_mode3_q", got[18].q, 16'hA57E);
        end

        // T5: random QPSK blocks with gaps and random back-pressure
        sop_base = n_sop;
        last_base = n_last;
        rnd_rdy = 1;
        for (int b = 0; b < 30; b++) begin
            for (int j = 0; j < 32; j++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                send(8'($urandom), j == 0, j == 31, 1'($urandom_range(0, 1)), 2'd1);
            end
        end
        drain();
        rnd_rdy = 0;
        rdy_val = 1;
        chk("t5_sop_count", n_sop - sop_base, 30);
        chk("t5_last_count", n_last - last_base, 30);

        // T6: reset mid-byte while stalled
        @(posedge clk);
        #1;
        rdy_val = 0;
        repeat (2) @(posedge clk);
        #1;
        clear_got();
        send(8'h1B, 1, 1, 0, 2'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_stalled_valid", m_axis_valid, 1);
        chk("t6_stalled_i", m_axis_i, 16'h5A82);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_stale_stalled", m_axis_valid, 0);
        rdy_val = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_stale_ready", m_axis_valid, 0);
        chk("t6_nothing_out", got.size(), 0);
        send(8'hE4, 1, 1, 0, 2'd1);
        drain();
        chk("t6_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t6_i0", got[0].i, 16'hA57E);
            chk("t6_q0", got[0].q, 16'hA57E);
            chk("t6_i3", got[3].i, 16'h5A82);
            chk("t6_last3", got[3].last, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
